// File: rtl/ipm_distributed_var_shiftregister_v1_0_if.sv
// ---------------------------------------------------------------------------
// ipm_distributed_var_shiftregister_v1_0_if
// Sample/control bundle for the variable-depth delay line.
//   i_aclken  : sample enable, one sample shifts in per high cycle
//   din       : input sample (DATA_WIDTH)
//   depth     : requested delay D (DW)
//   depth_ld  : single-cycle strobe to load depth
//   dout      : delayed sample, registered (DATA_WIDTH)
//   dout_vld  : dout holds a real sample delayed by cur_depth
//   depth_err : single-cycle pulse for a rejected depth_ld
//   cur_depth : active delay D (DW)
// Modports: master drives the inputs of the delay line, slave is the line.
// ---------------------------------------------------------------------------
interface ipm_distributed_var_shiftregister_v1_0_if #(
   parameter int VARIABLE_MAX_DEPTH = 16,
   parameter int DATA_WIDTH         = 16
);
   localparam int ADDR_WIDTH = (VARIABLE_MAX_DEPTH <= 16)  ? 4 :
                               (VARIABLE_MAX_DEPTH <= 32)  ? 5 :
                               (VARIABLE_MAX_DEPTH <= 64)  ? 6 :
                               (VARIABLE_MAX_DEPTH <= 128) ? 7 :
                               (VARIABLE_MAX_DEPTH <= 256) ? 8 :
                               (VARIABLE_MAX_DEPTH <= 512) ? 9 : 10;
   localparam int DW = ADDR_WIDTH + 1;

   logic                  i_aclken;
   logic [DATA_WIDTH-1:0] din;
   logic [DW-1:0]         depth;
   logic                  depth_ld;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_vld;
   logic                  depth_err;
   logic [DW-1:0]         cur_depth;

   modport master (
      output i_aclken, din, depth, depth_ld,
      input  dout, dout_vld, depth_err, cur_depth
   );

   modport slave (
      input  i_aclken, din, depth, depth_ld,
      output dout, dout_vld, depth_err, cur_depth
   );
endinterface

// File: rtl/ipm_distributed_var_shiftregister_v1_0.sv
// ---------------------------------------------------------------------------
// ipm_distributed_var_shiftregister_v1_0
// Runtime-variable delay line built on a 2**ADDR_WIDTH-entry distributed RAM.
// After k enabled samples since reset/flush, with k >= D, dout is the sample
// captured at enabled edge k-D+1; before that dout is held at zero.
// Ports:
//   clk      : clock, rising edge
//   asyn_rst : asynchronous active-high reset
//   bus      : slave side of ipm_distributed_var_shiftregister_v1_0_if
// ---------------------------------------------------------------------------
module ipm_distributed_var_shiftregister_v1_0 #(
   parameter int VARIABLE_MAX_DEPTH = 16,
   parameter int DATA_WIDTH         = 16
) (
   input  logic clk,
   input  logic asyn_rst,
   ipm_distributed_var_shiftregister_v1_0_if.slave bus
);
   localparam int ADDR_WIDTH = (VARIABLE_MAX_DEPTH <= 16)  ? 4 :
                               (VARIABLE_MAX_DEPTH <= 32)  ? 5 :
                               (VARIABLE_MAX_DEPTH <= 64)  ? 6 :
                               (VARIABLE_MAX_DEPTH <= 128) ? 7 :
                               (VARIABLE_MAX_DEPTH <= 256) ? 8 :
                               (VARIABLE_MAX_DEPTH <= 512) ? 9 : 10;
   localparam int DW      = ADDR_WIDTH + 1;
   localparam int RAM_LEN = 2 ** ADDR_WIDTH;

   typedef enum logic {FILL, RUN} state_t;

   logic [DATA_WIDTH-1:0] ram [RAM_LEN];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wp_q, wp_d;
   logic [DW-1:0]         fill_q, fill_d;
   logic [DW-1:0]         cur_depth_q, cur_depth_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  depth_err_q, depth_err_d;
   logic                  ram_we;
   logic                  load_ok;
   logic [ADDR_WIDTH-1:0] rd_addr;

   assign load_ok = bus.depth_ld && (bus.depth >= DW'(1)) &&
                    (bus.depth <= DW'(VARIABLE_MAX_DEPTH));

   // Entry written D-1 enabled edges ago; the modulo wrap falls out of the
   // ADDR_WIDTH truncation.
   assign rd_addr = wp_q - ADDR_WIDTH'(cur_depth_q - DW'(1));

   always_ff @(posedge clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         state_q     <= FILL;
         wp_q        <= '0;
         fill_q      <= '0;
         cur_depth_q <= DW'(VARIABLE_MAX_DEPTH);
         dout_q      <= '0;
         depth_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         fill_q      <= fill_d;
         cur_depth_q <= cur_depth_d;
         dout_q      <= dout_d;
         depth_err_q <= depth_err_d;
      end
   end

   // Storage is never reset; zero-masking during FILL hides stale entries.
   always_ff @(posedge clk) begin
      if (ram_we) ram[wp_q] <= bus.din;
   end

   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      fill_d      = fill_q;
      cur_depth_d = cur_depth_q;
      dout_d      = dout_q;
      depth_err_d = 1'b0;
      ram_we      = 1'b0;

      // The RAM keeps taking samples even on a load cycle.
      if (bus.i_aclken) begin
         ram_we = 1'b1;
         wp_d   = wp_q + ADDR_WIDTH'(1);
      end

      if (load_ok) begin
         cur_depth_d = bus.depth;
         fill_d      = '0;
         state_d     = FILL;
         dout_d      = '0;
      end else begin
         if (bus.depth_ld) depth_err_d = 1'b1;
         if (bus.i_aclken) begin
            if (fill_q < cur_depth_q) fill_d = fill_q + DW'(1);
            if (fill_q + DW'(1) >= cur_depth_q) begin
               state_d = RUN;
               // D=1 returns the sample being written this edge, which the
               // RAM does not hold yet.
               dout_d  = (cur_depth_q == DW'(1)) ? bus.din : ram[rd_addr];
            end
         end
      end
   end

   assign bus.dout      = dout_q;
   assign bus.dout_vld  = (state_q == RUN);
   assign bus.depth_err = depth_err_q;
   assign bus.cur_depth = cur_depth_q;
endmodule
